// File: rtl/uart_rx_if.sv
// Serial input and byte-output handshake between the UART receive stage and its consumer.
interface uart_rx_if;
  logic       RxD;
  logic [7:0] RxData;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output RxD, input RxData, valid, frame_err, busy);
  modport slave  (input RxD, output RxData, valid, frame_err, busy);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: two-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err pulses.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three synchronised values.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic     clk,
  input  logic     reset,
  uart_rx_if.slave bus
);
  // state   | meaning
  // S_IDLE  | line idle, waiting for a falling edge
  // S_START | counting to mid start bit, rejecting glitches
  // S_DATA  | shifting in 8 data bits, LSB first
  // S_STOP  | sampling stop bit, emitting valid or frame_err
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam int          HALF       = CLKS_PER_BIT / 2;
  localparam logic [13:0] LP_HALF_M1 = 14'(HALF - 1);
  localparam logic [13:0] LP_BIT_M1  = 14'(CLKS_PER_BIT - 1);

  state_t      r_state, w_state_nxt;
  logic        r_sync1, r_sync2, r_rx_prev;
  logic [13:0] r_counter, w_counter_nxt;
  logic [2:0]  r_bitcount, w_bitcount_nxt;
  logic [7:0]  r_sr, w_sr_nxt;
  logic [7:0]  r_rx_data, w_rx_data_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_frame_err, w_frame_err_nxt;
  logic        w_sample;
  logic        w_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= bus.RxD;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // r_hist[0] is the synchronised value one cycle back, r_hist[1] two cycles back.
  logic [1:0] r_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_hist <= 2'b11;
    else       r_hist <= {r_hist[0], r_sync2};
  end

  assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
`else
  assign w_sample = r_sync2;
`endif

  // A line held low leaves r_rx_prev low, so a break never looks like a new start edge.
  assign w_fall = r_rx_prev & ~r_sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_counter   <= '0;
      r_bitcount  <= '0;
      r_sr        <= '0;
      r_rx_data   <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_counter   <= w_counter_nxt;
      r_bitcount  <= w_bitcount_nxt;
      r_sr        <= w_sr_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_counter_nxt   = r_counter;
    w_bitcount_nxt  = r_bitcount;
    w_sr_nxt        = r_sr;
    w_rx_data_nxt   = r_rx_data;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_counter_nxt  = '0;
        w_bitcount_nxt = '0;
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_counter == LP_HALF_M1) begin
          w_counter_nxt  = '0;
          w_bitcount_nxt = '0;
          w_state_nxt    = w_sample ? S_IDLE : S_DATA;
        end else begin
          w_counter_nxt = r_counter + 14'd1;
        end
      end
      S_DATA: begin
        if (r_counter == LP_BIT_M1) begin
          w_sr_nxt       = {w_sample, r_sr[7:1]};
          w_counter_nxt  = '0;
          w_bitcount_nxt = r_bitcount + 3'd1;
          if (r_bitcount == 3'd7) w_state_nxt = S_STOP;
        end else begin
          w_counter_nxt = r_counter + 14'd1;
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (r_counter == LP_BIT_M1) begin
          w_counter_nxt = '0;
          w_state_nxt   = S_IDLE;
          if (w_sample) begin
            w_rx_data_nxt = r_sr;
            w_valid_nxt   = 1'b1;
          end else begin
            w_frame_err_nxt = 1'b1;
          end
        end else begin
          w_counter_nxt = r_counter + 14'd1;
        end
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_counter_nxt = '0;
      end
    endcase
  end

  assign bus.RxData    = r_rx_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = (r_state != S_IDLE);
endmodule

// File: doc/uart_receiver.md
# uart_receiver

- Serial-to-parallel UART receive stage, the downstream peer of the board's UART transmit path.
- Recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the asynchronous serial line.
- Presents each byte as a one-cycle `valid` pulse, and flags frames whose stop bit is low.
- Baud rate is set by a clock-divider parameter and defaults to 9600 baud from a 100 MHz clock.

## Interface
- `CLKS_PER_BIT`, 10416: clock cycles per serial bit; legal range 8..16383.
- `HALF`, `CLKS_PER_BIT/2` (integer divide): cycles from start-edge detection to mid-start-bit sample; derived, not overridden.
- `clk` in 1: UART clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `RxD` in 1: serial line, idle high, asynchronous to `clk`.
- `RxData` out 8: last correctly framed byte; holds until the next good frame.
- `valid` out 1: one-cycle pulse when `RxData` is updated.
- `frame_err` out 1: one-cycle pulse when the stop bit is sampled low.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Synchroniser:** `RxD` passes through a two-flop synchroniser; both flops reset to 1. The value `rx_prev` holds the previous synchronised sample.
- **Datapath:** 14-bit `counter`, 3-bit `bitcount`, 8-bit shift register `sr`.
- **IDLE:**
  - Counters cleared.
  - A falling edge (`rx_prev`=1, synchronised value=0) moves to START with `counter`=0.
  - A line held low, e.g. a break, does not retrigger.
- **START:**
  - `counter` increments each cycle.
  - At `counter`==HALF-1 the bit is sampled.
  - Sample 0: go to DATA, `counter`=0, `bitcount`=0.
  - Sample 1: glitch; return to IDLE with no output pulse.
- **DATA:**
  - `counter` counts 0..CLKS_PER_BIT-1.
  - At CLKS_PER_BIT-1: `sr` <= {sample, `sr`[7:1]}, `counter` <= 0, `bitcount` += 1.
  - After the sample with `bitcount`==7, go to STOP.
- **STOP:**
  - `counter` counts 0..CLKS_PER_BIT-1; at CLKS_PER_BIT-1 the stop bit is sampled.
  - Sample 1: `RxData` <= `sr`, `valid` pulses.
  - Sample 0: `frame_err` pulses and `RxData` is unchanged.
  - Either way, return to IDLE next cycle.
- **Mutual exclusion:** `valid` and `frame_err` are never high together.
- **Invalid state encodings:** go to IDLE.

## Timing
- **Reset values:** state IDLE; `RxData`=8'h00; `valid`=0; `frame_err`=0; `busy`=0; `counter`, `bitcount`, `sr` = 0; synchroniser = 1.
- **Reset effect:** immediate and asynchronous, including mid-frame. After release, a frame already in progress is discarded. Reception resumes at the next falling edge.
- **Output registration:** `valid` and `frame_err` are registered and asserted the cycle after the stop sample, for exactly 1 cycle.
- **Latency:** from the first `clk` edge that captures `RxD`=0 into the synchroniser to `valid` high is 2 + HALF + 9·CLKS_PER_BIT + 1 edges. The bench checks this within ±2 cycles.
- **Sample position:** data and stop samples fall at mid-bit ±1 cycle relative to the transmitted frame.
- **Back-to-back frames:** IDLE is re-entered before the end of the stop bit. The next start edge is accepted from the first cycle in IDLE, so no idle bit is required between frames.
- **Tolerance:** baud mismatch up to ±2 % between transmitter and receiver must still decode correctly.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:**
  - Each START, DATA and STOP sample is the 2-of-3 majority of synchronised values at `counter` == P-2, P-1 and P, where P is the normal sample point.
  - Requires CLKS_PER_BIT >= 8; a single-cycle line glitch at the sample point is rejected.
- **`UART_RX_MAJORITY_EN` undefined:** single sample at P. No extra registers are used.

## Test plan
- **Clean byte:** CLKS_PER_BIT=16; drive 8N1 frame 0xA5 -> one `valid` pulse, `RxData`=0xA5, `frame_err`=0, `busy` low 1 cycle after the pulse.
- **Back-to-back frames:** 0x00, 0xFF, 0x3C with no idle gap -> three `valid` pulses, `RxData` sequence 0x00, 0xFF, 0x3C, no `frame_err`.
- **Start-bit glitch:** low pulse of 4 cycles on an idle line -> no `valid`/`frame_err`, `busy` high ≤HALF+3 cycles then 0.
- **Framing error:** first receive 0x11, then frame 0x55 with stop bit 0 and the line held low for 3 bit times -> one `frame_err` pulse, `RxData` stays 0x11, no retrigger until the line rises and falls again.
- **Reset mid-frame:** assert `reset` during bit 4 of 0x96, release, then send 0x4B -> outputs at reset values during reset; only 0x4B is received, with `valid` pulsed once.
- **Majority vote:** with `UART_RX_MAJORITY_EN` defined, frame 0xF0 with a 1-cycle inverted glitch at each data sample point P -> `RxData`=0xF0. Without the macro the same stimulus yields corrupted data (bench checks RxData != 0xF0).
